// File: rtl/axi4_lite_req_arbiter_if.sv
// rtl/axi4_lite_req_arbiter_if.sv - requester-side and master-side signal bundle for axi4_lite_req_arbiter
interface axi4_lite_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_err;
    logic                      busy;
    logic                      m_transfer;
    logic                      m_write;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, m_ready, m_rdata,
        output req_grant, req_done, req_rdata, req_err, busy,
               m_transfer, m_write, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, m_ready, m_rdata,
        input  req_grant, req_done, req_rdata, req_err, busy,
               m_transfer, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/axi4_lite_req_arbiter.sv
// rtl/axi4_lite_req_arbiter.sv - round-robin share of one AXI4-Lite master request port; ARB_TIMEOUT_EN adds WAIT abort
module axi4_lite_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axi4_lite_req_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("axi4_lite_req_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    rr_idx;
    logic [IDX_W-1:0]    rr_cand;
    logic                rr_found;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_REQ-1:0]  owner_oh;
    logic                complete;
    logic                timed_out;
    logic                tmo_hit;
    logic                err_q;

    // First asserted request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr;
        rr_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!rr_found && bus.req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    assign owner_oh = NUM_REQ'(1) << win;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
                err_q    <= 1'b0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    // wait_cnt counts WAIT cycles already spent, so the abort lands TIMEOUT_CYC cycles in.
    assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        complete       = 1'b0;
        timed_out      = 1'b0;
        bus.busy       = (state != IDLE);
        bus.m_transfer = 1'b0;
        bus.req_grant  = '0;
        bus.req_done   = '0;
        bus.req_err    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.m_transfer = 1'b1;
                bus.req_grant  = owner_oh;
                complete       = bus.m_ready;
                state_nxt      = bus.m_ready ? DONE : WAIT;
            end
            WAIT: begin
                bus.req_grant = owner_oh;
                if (bus.m_ready) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    timed_out = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.req_grant = owner_oh;
                bus.req_done  = owner_oh;
                bus.req_err   = err_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ptr       <= '0;
            win       <= '0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && rr_found) begin
                win       <= rr_idx;
                cmd_write <= bus.req_write[rr_idx];
                cmd_addr  <= bus.req_addr[rr_idx*ADDR_W +: ADDR_W];
                cmd_wdata <= bus.req_wdata[rr_idx*DATA_W +: DATA_W];
            end
            if (complete && !cmd_write) begin
                rdata_q <= bus.m_rdata;
            end
            if (timed_out) begin
                rdata_q <= '0;
            end
            if (state == DONE) begin
                ptr <= IDX_W'((int'(win) + 1) % NUM_REQ);
            end
        end
    end

    assign bus.m_write   = cmd_write;
    assign bus.m_addr    = cmd_addr;
    assign bus.m_wdata   = cmd_wdata;
    assign bus.req_rdata = rdata_q;
endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// tb/tb_axi4_lite_req_arbiter.sv - randomized bench for axi4_lite_req_arbiter with transaction-level reference model
module tb_axi4_lite_req_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic ACLK = 1'b0;
    logic ARESET;

    axi4_lite_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4_lite_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus.slave)
    );

    always #5 ACLK = ~ACLK;

    int vectors    = 0;
    int miscompares = 0;

    // Requester agents
    logic [NUM_REQ-1:0] rv;
    logic               rw  [NUM_REQ];
    logic [ADDR_W-1:0]  ra  [NUM_REQ];
    logic [DATA_W-1:0]  rwd [NUM_REQ];
    bit                 done_seen [NUM_REQ];
    bit                 random_mode = 0;
    bit                 rereq = 0;

    // Master responder
    int                 mst_cnt = -1;
    int                 lat_fixed = 1;
    bit                 use_dir_rdata = 0;
    logic [DATA_W-1:0]  dir_rdata = '0;

    // Reference model: owner timeline measured in cycles since the issue cycle
    int                 m_ptr, m_owner, m_age;
    bit                 m_in_done, m_err;
    logic               m_wr;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wd, m_rd;

    logic [NUM_REQ-1:0] dut_log [$];
    logic [NUM_REQ-1:0] fair_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                         4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(int idx, logic [NUM_REQ-1:0] exp);
        if (idx < dut_log.size()) begin
            chk($sformatf("grant_order[%0d]", idx), dut_log[idx], exp);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL grant_order[%0d]: got none expected %0h", idx, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_age = 0; m_in_done = 0; m_err = 0;
        m_wr = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
    endtask

    task automatic model_update();
        bit found;
        found = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (!found && rv[c]) begin
                    found = 1;
                    m_owner = c; m_age = 0; m_in_done = 0; m_err = 0;
                    m_wr = rw[c]; m_addr = ra[c]; m_wd = rwd[c];
                end
            end
        end else if (m_in_done) begin
            done_seen[m_owner] = 1;
            m_ptr = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
            m_in_done = 0;
        end else begin
            if (bus.m_ready) begin
                if (!m_wr) m_rd = bus.m_rdata;
                m_in_done = 1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_age == TIMEOUT_CYC) begin
                m_in_done = 1; m_err = 1; m_rd = '0;
            end
`endif
            m_age++;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_REQ-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("busy",       bus.busy,       m_owner >= 0);
        chk("req_grant",  bus.req_grant,  eg);
        chk("req_done",   bus.req_done,   m_in_done ? eg : '0);
        chk("m_transfer", bus.m_transfer, (m_owner >= 0) && (m_age == 0));
        chk("req_err",    bus.req_err,    m_in_done && m_err);
        chk("m_write",    bus.m_write,    m_wr);
        chk("m_addr",     bus.m_addr,     m_addr);
        chk("m_wdata",    bus.m_wdata,    m_wd);
        chk("req_rdata",  bus.req_rdata,  m_rd);
    endtask

    task automatic apply_inputs();
        bus.req_valid = rv;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_write[i]                   = rw[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]   = ra[i];
            bus.req_wdata[i*DATA_W +: DATA_W]  = rwd[i];
        end
    endtask

    task automatic drive_requesters();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (done_seen[i]) begin
                rv[i] = 1'b0;
                done_seen[i] = 0;
            end else if (!rv[i] && m_owner != i &&
                         (rereq || (random_mode && $urandom_range(0, 3) == 0))) begin
                rv[i] = 1'b1;
                if (random_mode) begin
                    rw[i]  = 1'($urandom_range(0, 1));
                    ra[i]  = ADDR_W'($urandom);
                    rwd[i] = $urandom;
                end
            end else if (random_mode && rv[i] && m_owner == i) begin
                // Owned command is already latched; scramble payload and sometimes withdraw.
                rw[i]  = 1'($urandom_range(0, 1));
                ra[i]  = ADDR_W'($urandom);
                rwd[i] = $urandom;
                if ($urandom_range(0, 7) == 0) rv[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_master();
        bus.m_rdata = $urandom;
        bus.m_ready = 1'b0;
        if (bus.m_transfer) mst_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
        if (mst_cnt == 0) begin
            bus.m_ready = 1'b1;
            if (use_dir_rdata) bus.m_rdata = dir_rdata;
        end else if (mst_cnt < 0 && random_mode && (m_owner < 0 || m_in_done)
                     && $urandom_range(0, 7) == 0) begin
            bus.m_ready = 1'b1;
        end
        if (mst_cnt >= 0) mst_cnt--;
    endtask

    task automatic tick();
        drive_requesters();
        drive_master();
        apply_inputs();
        if (bus.m_transfer) dut_log.push_back(bus.req_grant);
        check_outputs();
        model_update();
        @(negedge ACLK);
    endtask

    task automatic reset_cycle();
        ARESET = 1'b1;
        bus.m_ready = 1'b0;
        mst_cnt = -1;
        apply_inputs();
        check_outputs();
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) done_seen[i] = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rv != '0 || m_owner >= 0) && g < 400) begin
            tick();
            g++;
        end
        vectors++;
        if (g >= 400) begin
            miscompares++;
            $display("FAIL drain: got still busy after %0d cycles expected idle", g);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        ARESET = 1'b1;
        rv = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0; done_seen[i] = 0;
        end
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        apply_inputs();
        repeat (2) @(negedge ACLK);
        model_reset();
        chk("reset_busy",     bus.busy,       1'b0);
        chk("reset_grant",    bus.req_grant,  4'b0000);
        chk("reset_done",     bus.req_done,   4'b0000);
        chk("reset_transfer", bus.m_transfer, 1'b0);
        chk("reset_m_addr",   bus.m_addr,     4'h0);
        chk("reset_rdata",    bus.req_rdata,  32'h0);
        ARESET = 1'b0;

        // Single write from requester 0
        lat_fixed = 2;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 4'h4; rwd[0] = 32'hA5A5_0001;
        tick();
        chk("wr_transfer", bus.m_transfer, 1'b1);
        chk("wr_grant",    bus.req_grant,  4'b0001);
        chk("wr_addr",     bus.m_addr,     4'h4);
        chk("wr_wdata",    bus.m_wdata,    32'hA5A5_0001);
        tick();
        chk("wr_addr_hold",  bus.m_addr,  4'h4);
        chk("wr_wdata_hold", bus.m_wdata, 32'hA5A5_0001);
        tick();
        chk("wr_wdata_hold2", bus.m_wdata, 32'hA5A5_0001);
        tick();
        chk("wr_done", bus.req_done, 4'b0001);
        repeat (2) tick();

        // Single read from requester 2
        lat_fixed = 1; use_dir_rdata = 1; dir_rdata = 32'h1234_5678;
        rv[2] = 1'b1; rw[2] = 1'b0; ra[2] = 4'h8; rwd[2] = '0;
        repeat (3) tick();
        chk("rd_done",  bus.req_done,  4'b0100);
        chk("rd_rdata", bus.req_rdata, 32'h1234_5678);
        tick();
        chk("rd_rdata_hold", bus.req_rdata, 32'h1234_5678);
        tick();
        use_dir_rdata = 0;

        // Reset in WAIT, then contention 4'b1010 from ptr=0
        lat_fixed = 20;
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 4'hC; rwd[1] = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk("pre_rst_busy", bus.busy, 1'b1);
        rv[3] = 1'b1; rw[3] = 1'b0; ra[3] = 4'h3; rwd[3] = '0;
        lat_fixed = 1;
        reset_cycle();
        chk("rst_busy",  bus.busy,      1'b0);
        chk("rst_grant", bus.req_grant, 4'b0000);
        chk("rst_done",  bus.req_done,  4'b0000);
        dut_log.delete();
        tick();
        chk("rst_ptr_grant", bus.req_grant, 4'b0010);
        repeat (12) tick();
        chk_log(0, 4'b0010);
        chk_log(1, 4'b1000);
        drain();

        // Fairness with all requesters continuously asking
        dut_log.delete();
        lat_fixed = -1;
        rereq = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rw[i] = 1'(i % 2); ra[i] = ADDR_W'(i + 1); rwd[i] = 32'h100 + 32'(i);
        end
        guard = 0;
        while (dut_log.size() < 8 && guard < 300) begin
            tick();
            guard++;
        end
        rereq = 0;
        for (int k = 0; k < 8; k++) chk_log(k, fair_exp[k]);
        drain();

        // Randomized traffic
        random_mode = 1;
        repeat (3000) tick();
        random_mode = 0;
        drain();

        // Master never answers
        lat_fixed = 1000;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 4'h3; rwd[0] = '0;
        tick();
        repeat (17) tick();
`ifdef ARB_TIMEOUT_EN
        chk("tmo_done",  bus.req_done,  4'b0001);
        chk("tmo_err",   bus.req_err,   1'b1);
        chk("tmo_rdata", bus.req_rdata, 32'h0);
`else
        chk("no_tmo_busy", bus.busy,     1'b1);
        chk("no_tmo_done", bus.req_done, 4'b0000);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
